// File: rtl/parity_gen_chk_pipe.sv
// Two-stage valid/ready pipeline that generates or checks per-lane odd/even parity,
// with a sticky error flag and a saturating count of delivered error beats.
module parity_gen_chk_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PARITY_WIDTH  = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [PARITY_WIDTH-1:0]  i_parity,
  input  logic                     i_odd,
  input  logic                     i_chk,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [PARITY_WIDTH-1:0]  o_parity,
  output logic [PARITY_WIDTH-1:0]  o_err_lane,
  output logic                     o_err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  input  logic                     i_clr_err
);

  localparam int unsigned LaneW = DATA_WIDTH / PARITY_WIDTH;

  if (DATA_WIDTH % PARITY_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of PARITY_WIDTH");
  end

  logic                     s1_v_q, s2_v_q;
  logic [DATA_WIDTH-1:0]    s1_data_q, s2_data_q;
  logic [PARITY_WIDTH-1:0]  s1_par_q, s2_par_q, s2_err_q;
  logic                     s1_odd_q, s1_chk_q;
  logic [PARITY_WIDTH-1:0]  s1_p, s1_err;
  logic                     s1_adv, s2_adv, err_beat;
  logic                     err_sticky_d, err_sticky_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_d, err_cnt_q;

  assign s2_adv  = ~s2_v_q | i_ready;
  assign s1_adv  = ~s1_v_q | s2_adv;
  assign o_ready = s1_adv;

  // Odd parity is the even result inverted.
  always_comb begin
    s1_p = '0;
    for (int unsigned k = 0; k < PARITY_WIDTH; k++) begin
      s1_p[k] = (^s1_data_q[k*LaneW +: LaneW]) ^ s1_odd_q;
    end
    s1_err = s1_chk_q ? (s1_p ^ s1_par_q) : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_par_q  <= '0;
      s1_odd_q  <= 1'b0;
      s1_chk_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_par_q  <= '0;
      s2_err_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= i_valid;
        if (i_valid) begin
          s1_data_q <= i_data;
          s1_par_q  <= i_parity;
          s1_odd_q  <= i_odd;
          s1_chk_q  <= i_chk;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_data_q <= s1_data_q;
          s2_par_q  <= s1_p;
          s2_err_q  <= s1_err;
        end
      end
    end
  end

  // Errors are counted on the output transfer so a stalled beat counts once.
  assign err_beat = s2_v_q & i_ready & (|s2_err_q);

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (err_beat) begin
      err_sticky_d = 1'b1;
      if (i_clr_err) begin
        err_cnt_d = ERR_CNT_WIDTH'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (i_clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_valid      = s2_v_q;
  assign o_data       = s2_data_q;
  assign o_parity     = s2_par_q;
  assign o_err_lane   = s2_err_q;
  assign o_err_sticky = err_sticky_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_gen_chk_pipe.sv
// Scoreboard bench: driver pushes hand-computed expectations on accept, monitor checks on output.
module tb_parity_gen_chk_pipe;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, o_ready;
  logic [31:0] i_data = '0;
  logic [3:0]  i_parity = '0;
  logic        i_odd = 1'b0, i_chk = 1'b0;
  logic        o_valid, i_ready = 1'b1;
  logic [31:0] o_data;
  logic [3:0]  o_parity, o_err_lane;
  logic        o_err_sticky;
  logic [1:0]  o_err_cnt;
  logic        i_clr_err = 1'b0;

  parity_gen_chk_pipe #(
    .DATA_WIDTH   (32),
    .PARITY_WIDTH (4),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_parity    (i_parity),
    .i_odd       (i_odd),
    .i_chk       (i_chk),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_parity    (o_parity),
    .o_err_lane  (o_err_lane),
    .o_err_sticky(o_err_sticky),
    .o_err_cnt   (o_err_cnt),
    .i_clr_err   (i_clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  par;
    logic [3:0]  err;
  } exp_t;

  exp_t       q[$];
  exp_t       cur_exp;
  int         n_chk = 0;
  int         n_pass = 0;
  logic       m_sticky = 1'b0;
  logic [1:0] m_cnt = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: checks the head of the scoreboard every cycle o_valid is up, so a stalled
  // beat must stay equal to its expectation until it is taken.
  always @(negedge clk) begin
    exp_t e;
    logic eb;
    if (i_rst) begin
      q.delete();
      m_sticky = 1'b0;
      m_cnt    = 2'd0;
      check("rst_o_valid", {31'd0, o_valid}, 32'd0);
      check("rst_o_data", o_data, 32'd0);
      check("rst_cnt", {30'd0, o_err_cnt}, 32'd0);
      check("rst_sticky", {31'd0, o_err_sticky}, 32'd0);
    end else begin
      check("o_ready", {31'd0, o_ready}, {31'd0, !(q.size() == 2 && !i_ready)});
      check("err_cnt", {30'd0, o_err_cnt}, {30'd0, m_cnt});
      check("err_sticky", {31'd0, o_err_sticky}, {31'd0, m_sticky});
      eb = 1'b0;
      if (o_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", {31'd0, o_valid}, 32'd0);
        end else begin
          e = q[0];
          check("o_data", o_data, e.data);
          check("o_parity", {28'd0, o_parity}, {28'd0, e.par});
          check("o_err_lane", {28'd0, o_err_lane}, {28'd0, e.err});
          if (i_ready) begin
            eb = (e.err != 4'd0);
            void'(q.pop_front());
          end
        end
      end
      if (eb) begin
        m_sticky = 1'b1;
        m_cnt    = i_clr_err ? 2'd1 : (m_cnt == 2'd3 ? 2'd3 : m_cnt + 2'd1);
      end else if (i_clr_err) begin
        m_sticky = 1'b0;
        m_cnt    = 2'd0;
      end
      if (i_valid && o_ready) q.push_back(cur_exp);
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] rp, input logic odd,
                      input logic chk, input logic [3:0] ep, input logic [3:0] ee);
    bit acc;
    int n;
    i_valid = 1'b1; i_data = d; i_parity = rp; i_odd = odd; i_chk = chk;
    cur_exp = '{data: d, par: ep, err: ee};
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL send_timeout: not accepted after %0d cycles, expected accept", n);
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", q.size());
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // Generate mode: all-zero data
    send(32'h0000_0000, 4'h0, 1'b1, 1'b0, 4'hF, 4'h0);
    send(32'h0000_0000, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    drain();

    // Check mode: single-bit error on lane 0
    send(32'h0000_0001, 4'hF, 1'b1, 1'b1, 4'hE, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    check("t2_cnt", {30'd0, o_err_cnt}, 32'd1);
    check("t2_sticky", {31'd0, o_err_sticky}, 32'd1);

    // Back-to-back stream with a 5-cycle downstream stall
    fork
      begin
        send(32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        send(32'h0102_0304, 4'h0, 1'b0, 1'b0, 4'hD, 4'h0);
        send(32'h8000_0000, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0);
        send(32'h00FF_0007, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0);
        send(32'hA5A5_A5A5, 4'h0, 1'b1, 1'b0, 4'hF, 4'h0);
        send(32'h7F00_0000, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0);
        send(32'h1122_3344, 4'h0, 1'b1, 1'b0, 4'hF, 4'h0);
        send(32'hDEAD_BEEF, 4'h0, 1'b0, 1'b0, 4'h5, 4'h0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    // Saturation of a 2-bit counter, then clear colliding with an error beat
    i_clr_err = 1'b1;
    @(posedge clk);
    #1 i_clr_err = 1'b0;
    check("t4_cleared", {30'd0, o_err_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) send(32'h0000_0001, 4'hF, 1'b1, 1'b1, 4'hE, 4'h1);
    drain();
    @(posedge clk);
    #1;
    check("t4_saturated", {30'd0, o_err_cnt}, 32'd3);
    i_ready = 1'b0;
    send(32'h0000_0001, 4'hF, 1'b1, 1'b1, 4'hE, 4'h1);
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_valid_seen", {31'd0, o_valid}, 32'd1);
    i_clr_err = 1'b1;
    i_ready   = 1'b1;
    @(posedge clk);
    #1 i_clr_err = 1'b0;
    check("t4_clr_vs_err_cnt", {30'd0, o_err_cnt}, 32'd1);
    check("t4_clr_vs_err_sticky", {31'd0, o_err_sticky}, 32'd1);

    // Parity sense toggled per beat on constant data
    send(32'h1234_5678, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0);
    send(32'h1234_5678, 4'h0, 1'b1, 1'b0, 4'hB, 4'h0);
    send(32'h1234_5678, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0);
    send(32'h1234_5678, 4'h0, 1'b1, 1'b0, 4'hB, 4'h0);
    drain();

    // Reset with two beats in flight
    i_ready = 1'b0;
    send(32'h0102_0304, 4'h0, 1'b0, 1'b0, 4'hD, 4'h0);
    send(32'h8000_0000, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0);
    i_rst = 1'b1;
    #1;
    check("t6_valid_now", {31'd0, o_valid}, 32'd0);
    check("t6_cnt_now", {30'd0, o_err_cnt}, 32'd0);
    check("t6_sticky_now", {31'd0, o_err_sticky}, 32'd0);
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    send(32'hDEAD_BEEF, 4'h0, 1'b0, 1'b0, 4'h5, 4'h0);
    check("t6_lat1_valid", {31'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t6_lat2_valid", {31'd0, o_valid}, 32'd1);
    check("t6_lat2_data", o_data, 32'hDEAD_BEEF);
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
